// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-port synchronous SRAM.
// Define SRAM_ARB_FIXED_PRIO_EN to make port 0 always win contention instead.

module sram_arb_port #(
    parameter int WIDTH = 32
) (
    input  logic             sel,
    input  logic             resp,
    input  logic [WIDTH-1:0] sram_rdata,
    output logic             rvalid,
    output logic [WIDTH-1:0] rdata
);
    // Read data is forced to zero outside the owner's response cycle.
    assign rvalid = sel & resp;
    assign rdata  = rvalid ? sram_rdata : '0;
endmodule

module sram_arbiter #(
    parameter int ADDR  = 8,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m0_req,
    input  logic             m0_we,
    input  logic [ADDR-1:0]  m0_addr,
    input  logic [WIDTH-1:0] m0_wdata,
    output logic             m0_gnt,
    output logic             m0_rvalid,
    output logic [WIDTH-1:0] m0_rdata,
    input  logic             m1_req,
    input  logic             m1_we,
    input  logic [ADDR-1:0]  m1_addr,
    input  logic [WIDTH-1:0] m1_wdata,
    output logic             m1_gnt,
    output logic             m1_rvalid,
    output logic [WIDTH-1:0] m1_rdata,
    output logic             sram_cs,
    output logic             sram_we,
    output logic [ADDR-1:0]  sram_addr,
    output logic [WIDTH-1:0] sram_wdata,
    input  logic [WIDTH-1:0] sram_rdata
);
    localparam int NUM_PORTS = 2;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                            state;
    logic                              cs_q;
    logic                              owner;
    logic                              win;
    logic                              any_req;
    logic                              resp;
    logic [NUM_PORTS-1:0]              req;
    logic [NUM_PORTS-1:0]              we;
    logic [NUM_PORTS-1:0]              gnt;
    logic [NUM_PORTS-1:0]              rvalid;
    logic [NUM_PORTS-1:0][ADDR-1:0]    addr;
    logic [NUM_PORTS-1:0][WIDTH-1:0]   wdata;
    logic [NUM_PORTS-1:0][WIDTH-1:0]   rdata;

    assign req   = {m1_req, m0_req};
    assign we    = {m1_we, m0_we};
    assign addr  = {m1_addr, m0_addr};
    assign wdata = {m1_wdata, m0_wdata};

    assign any_req = |req;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    always_comb begin
        win = 1'b0;
        if (!req[0] && req[1])
            win = 1'b1;
    end
`else
    logic last;

    // Under contention the port that did not win last time goes first.
    always_comb begin
        win = 1'b0;
        if (req[0] && req[1])
            win = ~last;
        else if (req[1])
            win = 1'b1;
    end
`endif

    always_comb begin
        gnt = '0;
        if (state == IDLE && any_req && !rst)
            gnt[win] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cs_q       <= 1'b0;
            owner      <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            last       <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        cs_q       <= 1'b1;
                        owner      <= win;
                        sram_we    <= we[win];
                        sram_addr  <= addr[win];
                        sram_wdata <= wdata[win];
`ifndef SRAM_ARB_FIXED_PRIO_EN
                        last       <= win;
`endif
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    cs_q    <= 1'b0;
                    sram_we <= 1'b0;
                    state   <= sram_we ? IDLE : RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Gating with rst keeps a write whose access cycle meets reset from committing.
    assign sram_cs = cs_q & ~rst;
    assign resp    = (state == RESP) & ~rst;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        localparam logic PORT_ID = 1'(g);
        sram_arb_port #(.WIDTH(WIDTH)) u_port (
            .sel        (owner == PORT_ID),
            .resp       (resp),
            .sram_rdata (sram_rdata),
            .rvalid     (rvalid[g]),
            .rdata      (rdata[g])
        );
    end

    assign m0_gnt    = gnt[0];
    assign m1_gnt    = gnt[1];
    assign m0_rvalid = rvalid[0];
    assign m1_rvalid = rvalid[1];
    assign m0_rdata  = rdata[0];
    assign m1_rdata  = rdata[1];
endmodule

// File: tb/tb_sram_arbiter.sv
// Cycle-table bench for sram_arbiter with a behavioural single-port SRAM;
// contention expectations follow SRAM_ARB_FIXED_PRIO_EN when it is defined.

module tb_sram_arbiter;
    localparam int ADDR  = 8;
    localparam int WIDTH = 32;
`ifdef SRAM_ARB_FIXED_PRIO_EN
    localparam bit FP = 1'b1;
`else
    localparam bit FP = 1'b0;
`endif
    localparam logic [31:0] DB  = 32'hDEADBEEF;
    localparam logic [31:0] NW  = 32'h12345678;
    localparam logic [31:0] OLD = 32'hA5A5A5A5;

    logic clk = 1'b0;
    logic rst;
    logic m0_req, m0_we, m1_req, m1_we;
    logic [ADDR-1:0] m0_addr, m1_addr;
    logic [WIDTH-1:0] m0_wdata, m1_wdata;
    logic m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [WIDTH-1:0] m0_rdata, m1_rdata;
    logic sram_cs, sram_we;
    logic [ADDR-1:0] sram_addr;
    logic [WIDTH-1:0] sram_wdata;
    logic [WIDTH-1:0] sram_rdata = '0;

    logic [WIDTH-1:0] mem [0:(1<<ADDR)-1];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR(ADDR), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // SRAM model: write on CS&WE, registered read data.
    always @(posedge clk) begin
        if (sram_cs && sram_we) mem[sram_addr] <= sram_wdata;
        if (sram_cs) sram_rdata <= mem[sram_addr];
    end

    typedef struct {
        logic rst;
        logic q0, w0; logic [7:0] a0; logic [31:0] d0;
        logic q1, w1; logic [7:0] a1; logic [31:0] d1;
        logic g0, g1, v0, v1;
        logic [31:0] r0, r1;
        logic cs, we; logic [7:0] sa;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t v(input logic r,
                               input logic q0, w0, input logic [7:0] a0, input logic [31:0] d0,
                               input logic q1, w1, input logic [7:0] a1, input logic [31:0] d1,
                               input logic g0, g1, v0, v1,
                               input logic [31:0] r0, r1,
                               input logic cs, we, input logic [7:0] sa);
        vec_t t;
        t.rst = r;
        t.q0 = q0; t.w0 = w0; t.a0 = a0; t.d0 = d0;
        t.q1 = q1; t.w1 = w1; t.a1 = a1; t.d1 = d1;
        t.g0 = g0; t.g1 = g1; t.v0 = v0; t.v1 = v1;
        t.r0 = r0; t.r1 = r1;
        t.cs = cs; t.we = we; t.sa = sa;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        rst = t.rst;
        m0_req = t.q0; m0_we = t.w0; m0_addr = t.a0; m0_wdata = t.d0;
        m1_req = t.q1; m1_we = t.w1; m1_addr = t.a1; m1_wdata = t.d1;
    endtask

    // Raise one request, wait (bounded) for its grant and, for reads, its data.
    task automatic do_op(input bit p, input bit w, input logic [7:0] a,
                         input logic [31:0] d, input logic [31:0] exp);
        bit got;
        if (p) begin m1_req = 1; m1_we = w; m1_addr = a; m1_wdata = d; end
        else   begin m0_req = 1; m0_we = w; m0_addr = a; m0_wdata = d; end
        got = 0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (p ? m1_gnt : m0_gnt) got = 1;
            @(posedge clk); #1;
        end
        m0_req = 0; m1_req = 0;
        chk($sformatf("op_gnt p%0d a%h", p, a), 32'(got), 32'd1);
        if (!w) begin
            got = 0;
            for (int n = 0; n < 5 && !got; n++) begin
                @(negedge clk);
                if (p ? m1_rvalid : m0_rvalid) begin
                    got = 1;
                    chk($sformatf("op_rdata p%0d a%h", p, a), p ? m1_rdata : m0_rdata, exp);
                end
                @(posedge clk); #1;
            end
            chk($sformatf("op_rvalid p%0d a%h", p, a), 32'(got), 32'd1);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR); i++) mem[i] = 32'hC0DE0000 | 32'(i);
        mem[8'h10] = DB;
        mem[8'h20] = OLD;

        // single read, write then read, idle, reset with both requesting
        tv.push_back(v(1, 0,0,8'h00,0, 0,0,8'h00,0, 0,0,0,0, 0,0, 0,0,8'h00));
        tv.push_back(v(0, 1,0,8'h10,0, 0,0,8'h00,0, 1,0,0,0, 0,0, 0,0,8'h00));
        tv.push_back(v(0, 0,0,8'h00,0, 0,0,8'h00,0, 0,0,0,0, 0,0, 1,0,8'h10));
        tv.push_back(v(0, 0,0,8'h00,0, 0,0,8'h00,0, 0,0,1,0, DB,0, 0,0,8'h00));
        tv.push_back(v(0, 0,0,8'h00,0, 1,1,8'h05,NW, 0,1,0,0, 0,0, 0,0,8'h00));
        tv.push_back(v(0, 0,0,8'h00,0, 0,0,8'h00,0, 0,0,0,0, 0,0, 1,1,8'h05));
        tv.push_back(v(0, 0,0,8'h00,0, 1,0,8'h05,0, 0,1,0,0, 0,0, 0,0,8'h00));
        tv.push_back(v(0, 0,0,8'h00,0, 0,0,8'h00,0, 0,0,0,0, 0,0, 1,0,8'h05));
        tv.push_back(v(0, 0,0,8'h00,0, 0,0,8'h00,0, 0,0,0,1, 0,NW, 0,0,8'h00));
        tv.push_back(v(0, 0,0,8'h00,0, 0,0,8'h00,0, 0,0,0,0, 0,0, 0,0,8'h00));
        tv.push_back(v(1, 1,0,8'h10,0, 1,0,8'h05,0, 0,0,0,0, 0,0, 0,0,8'h00));
        // contention: four grants, 3 cycles apart
        for (int k = 0; k < 4; k++) begin
            bit p;
            p = FP ? 1'b0 : k[0];
            tv.push_back(v(0, 1,0,8'h10,0, 1,0,8'h05,0, !p,p,0,0, 0,0, 0,0,8'h00));
            tv.push_back(v(0, 1,0,8'h10,0, 1,0,8'h05,0, 0,0,0,0, 0,0, 1,0, p ? 8'h05 : 8'h10));
            tv.push_back(v(0, 1,0,8'h10,0, 1,0,8'h05,0, 0,0,!p,p, p ? 32'h0 : DB, p ? NW : 32'h0, 0,0,8'h00));
        end
        // port 0 released: port 1 served at the next idle
        tv.push_back(v(0, 0,0,8'h00,0, 1,0,8'h05,0, 0,1,0,0, 0,0, 0,0,8'h00));
        tv.push_back(v(0, 0,0,8'h00,0, 0,0,8'h00,0, 0,0,0,0, 0,0, 1,0,8'h05));
        tv.push_back(v(0, 0,0,8'h00,0, 0,0,8'h00,0, 0,0,0,1, 0,NW, 0,0,8'h00));
        // reset in RESP of a read, then a new read is accepted
        tv.push_back(v(0, 1,0,8'h10,0, 0,0,8'h00,0, 1,0,0,0, 0,0, 0,0,8'h00));
        tv.push_back(v(0, 0,0,8'h00,0, 0,0,8'h00,0, 0,0,0,0, 0,0, 1,0,8'h10));
        tv.push_back(v(1, 0,0,8'h00,0, 0,0,8'h00,0, 0,0,0,0, 0,0, 0,0,8'h00));
        tv.push_back(v(0, 0,0,8'h00,0, 0,0,8'h00,0, 0,0,0,0, 0,0, 0,0,8'h00));
        tv.push_back(v(0, 1,0,8'h20,0, 0,0,8'h00,0, 1,0,0,0, 0,0, 0,0,8'h00));
        tv.push_back(v(0, 0,0,8'h00,0, 0,0,8'h00,0, 0,0,0,0, 0,0, 1,0,8'h20));
        tv.push_back(v(0, 0,0,8'h00,0, 0,0,8'h00,0, 0,0,1,0, OLD,0, 0,0,8'h00));
        // reset in ACCESS of a write: memory keeps its old value
        tv.push_back(v(0, 0,0,8'h00,0, 1,1,8'h20,32'h11111111, 0,1,0,0, 0,0, 0,0,8'h00));
        tv.push_back(v(1, 0,0,8'h00,0, 0,0,8'h00,0, 0,0,0,0, 0,0, 0,0,8'h00));
        tv.push_back(v(0, 0,0,8'h00,0, 1,0,8'h20,0, 0,1,0,0, 0,0, 0,0,8'h00));
        tv.push_back(v(0, 0,0,8'h00,0, 0,0,8'h00,0, 0,0,0,0, 0,0, 1,0,8'h20));
        tv.push_back(v(0, 0,0,8'h00,0, 0,0,8'h00,0, 0,0,0,1, 0,OLD, 0,0,8'h00));

        drive(tv[0]);
        @(posedge clk); #1;

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i]);
            @(negedge clk);
            chk($sformatf("row%0d gnt", i), 32'({m1_gnt, m0_gnt}), 32'({tv[i].g1, tv[i].g0}));
            chk($sformatf("row%0d rvalid", i), 32'({m1_rvalid, m0_rvalid}), 32'({tv[i].v1, tv[i].v0}));
            chk($sformatf("row%0d m0_rdata", i), m0_rdata, tv[i].r0);
            chk($sformatf("row%0d m1_rdata", i), m1_rdata, tv[i].r1);
            chk($sformatf("row%0d sram_cs", i), 32'(sram_cs), 32'(tv[i].cs));
            if (tv[i].cs) begin
                chk($sformatf("row%0d sram_we", i), 32'(sram_we), 32'(tv[i].we));
                chk($sformatf("row%0d sram_addr", i), 32'(sram_addr), 32'(tv[i].sa));
            end
            @(posedge clk); #1;
        end

        m0_req = 0; m1_req = 0; rst = 0;
        do_op(0, 1, 8'h40, 32'hCAFEF00D, 32'h0);
        do_op(1, 0, 8'h40, 32'h0, 32'hCAFEF00D);
        do_op(1, 1, 8'hFF, 32'h0BADF00D, 32'h0);
        do_op(0, 0, 8'hFF, 32'h0, 32'h0BADF00D);
        do_op(0, 0, 8'h00, 32'h0, 32'hC0DE0000);
        do_op(1, 0, 8'h05, 32'h0, NW);

        // idle stability
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("idle%0d", i), 32'({sram_cs, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}), 32'h0);
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
